// File: rtl/input_port_update_arbiter_pkg.sv
// Shared constants, FSM state type and index helper for the freespace-update arbiter.
package input_port_arb_pkg;

  localparam int DEF_PACKET_BITS  = 97;
  localparam int DEF_NUM_IN_PORTS = 7;
  localparam int DEF_CNT_BITS     = 16;
  localparam int PTR_BITS         = $clog2(DEF_NUM_IN_PORTS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  // Circular successor of idx in a ring of n entries.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/input_port_update_arbiter_if.sv
// Update-request bus from the input-port cluster plus the merged packet stream and status.
interface input_port_update_arbiter_if
  import input_port_arb_pkg::*;
#(
  parameter int PACKET_BITS  = DEF_PACKET_BITS,
  parameter int NUM_IN_PORTS = DEF_NUM_IN_PORTS,
  parameter int CNT_BITS     = DEF_CNT_BITS
);

  logic [NUM_IN_PORTS-1:0]             freespace_update;
  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports;
  logic [PACKET_BITS-1:0]              pkt_out;
  logic                                pkt_out_vld;
  logic                                pkt_out_rdy;
  logic [NUM_IN_PORTS-1:0]             grant;
  logic [NUM_IN_PORTS-1:0]             pending;
  logic [CNT_BITS-1:0]                 overwrite_cnt;
  logic                                arb_busy;

  // Arbiter side.
  modport master (
    input  freespace_update, packet_from_input_ports, pkt_out_rdy,
    output pkt_out, pkt_out_vld, grant, pending, overwrite_cnt, arb_busy
  );

  // Input ports and downstream multiplexer side.
  modport slave (
    output freespace_update, packet_from_input_ports, pkt_out_rdy,
    input  pkt_out, pkt_out_vld, grant, pending, overwrite_cnt, arb_busy
  );

endinterface

// File: rtl/input_port_update_arbiter_rr_pick.sv
// Combinational round-robin search: first set pending bit at or after the pointer, wrapping.
module rr_pick
  import input_port_arb_pkg::*;
#(
  parameter int NUM_IN_PORTS = DEF_NUM_IN_PORTS,
  parameter int PTR_W        = PTR_BITS
) (
  input  logic [NUM_IN_PORTS-1:0] pending_i,
  input  logic [PTR_W-1:0]        pointer_i,
  output logic                    found_o,
  output logic [PTR_W-1:0]        idx_o
);

  logic [2*NUM_IN_PORTS-1:0] doubled;
  logic [NUM_IN_PORTS-1:0]   rotated;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign doubled = {pending_i, pending_i};
  assign rotated = NUM_IN_PORTS'(doubled >> pointer_i);

  always_comb begin
    logic hit;
    int   sum;
    hit   = 1'b0;
    sum   = 0;
    idx_o = '0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      if (!hit && rotated[k]) begin
        hit = 1'b1;
        sum = int'(pointer_i) + k;
        if (sum >= NUM_IN_PORTS) begin
          sum = sum - NUM_IN_PORTS;
        end
        idx_o = PTR_W'(sum);
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/input_port_update_arbiter.sv
// Latches per-port freespace-update packets and grants them round-robin onto one valid/ready stream.
module input_port_update_arbiter
  import input_port_arb_pkg::*;
#(
  parameter int PACKET_BITS  = DEF_PACKET_BITS,
  parameter int NUM_IN_PORTS = DEF_NUM_IN_PORTS,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input logic                         clk,
  input logic                         reset,
  input_port_update_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int SUM_W = CNT_BITS + 1;
  localparam logic [NUM_IN_PORTS-1:0] ONE_HOT0 = NUM_IN_PORTS'(1);

  arb_state_e              state_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        gidx_q;
  logic                    resend_q;
  logic [NUM_IN_PORTS-1:0] pending_q;
  logic [NUM_IN_PORTS-1:0] pending_d;
  logic [NUM_IN_PORTS-1:0] grant_q;
  logic [PACKET_BITS-1:0]  pkt_out_q;
  logic                    pkt_out_vld_q;
  logic [CNT_BITS-1:0]     ovw_cnt_q;
  logic [CNT_BITS-1:0]     ovw_cnt_d;
  logic [SUM_W-1:0]        ovw_sum;

  logic                    accept;
  logic [NUM_IN_PORTS-1:0] accept_vec;
  logic [NUM_IN_PORTS-1:0] clear_vec;
  logic [NUM_IN_PORTS-1:0] ovw_vec;
  logic [PACKET_BITS-1:0]  pkt_arr [NUM_IN_PORTS];
  logic                    pick_found;
  logic [PTR_W-1:0]        pick_idx;

  assign accept = (state_q == SEND) && bus.pkt_out_rdy;

  // A port whose register was refreshed after its grant keeps pending through the accept,
  // so the newer value still goes out on a later grant.
  for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_port
    logic [PACKET_BITS-1:0] pkt_q;

    assign accept_vec[gi] = accept && (gidx_q == PTR_W'(gi));
    assign clear_vec[gi]  = accept_vec[gi] && !resend_q;
    assign ovw_vec[gi]    = bus.freespace_update[gi] && pending_q[gi] && !accept_vec[gi];
    assign pending_d[gi]  = bus.freespace_update[gi] || (pending_q[gi] && !clear_vec[gi]);

    always_ff @(posedge clk) begin
      if (bus.freespace_update[gi]) begin
        pkt_q <= bus.packet_from_input_ports[PACKET_BITS*gi +: PACKET_BITS];
      end
    end

    assign pkt_arr[gi] = pkt_q;
  end

  // Several ports can overwrite in the same cycle; the sum carries one spare bit for saturation.
  always_comb begin
    ovw_sum = {1'b0, ovw_cnt_q};
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      ovw_sum = ovw_sum + SUM_W'(ovw_vec[k]);
    end
    ovw_cnt_d = ovw_sum[CNT_BITS] ? {CNT_BITS{1'b1}} : ovw_sum[CNT_BITS-1:0];
  end

  rr_pick #(
    .NUM_IN_PORTS (NUM_IN_PORTS),
    .PTR_W        (PTR_W)
  ) u_rr_pick (
    .pending_i (pending_q),
    .pointer_i (ptr_q),
    .found_o   (pick_found),
    .idx_o     (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gidx_q        <= '0;
      resend_q      <= 1'b0;
      pending_q     <= '0;
      grant_q       <= '0;
      pkt_out_q     <= '0;
      pkt_out_vld_q <= 1'b0;
      ovw_cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovw_cnt_q <= ovw_cnt_d;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gidx_q        <= pick_idx;
            pkt_out_q     <= pkt_arr[pick_idx];
            grant_q       <= ONE_HOT0 << pick_idx;
            pkt_out_vld_q <= 1'b1;
            resend_q      <= bus.freespace_update[pick_idx];
            state_q       <= SEND;
          end
        end
        SEND: begin
          if (bus.pkt_out_rdy) begin
            ptr_q         <= PTR_W'(next_index(int'(gidx_q), NUM_IN_PORTS));
            pkt_out_vld_q <= 1'b0;
            grant_q       <= '0;
            resend_q      <= 1'b0;
            state_q       <= IDLE;
          end else if (bus.freespace_update[gidx_q]) begin
            resend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pkt_out       = pkt_out_q;
  assign bus.pkt_out_vld   = pkt_out_vld_q;
  assign bus.grant         = grant_q;
  assign bus.pending       = pending_q;
  assign bus.overwrite_cnt = ovw_cnt_q;
  assign bus.arb_busy      = (state_q == SEND) || (|pending_q);

endmodule
